// File: rtl/tone_pkg.sv
// Shared state type and note divisor table for the tone sequencer.
package tone_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} seq_state_t;

  localparam int unsigned MAX_NOTES = 8;

  // Do..Do' divisors for a 50 MHz clock.
  localparam logic [31:0] NOTE_DIV [MAX_NOTES] = '{
    32'd47801, 32'd42590, 32'd37936, 32'd35816,
    32'd31887, 32'd28409, 32'd25330, 32'd23900
  };

  function automatic logic [31:0] note_div(input logic [2:0] idx);
    return NOTE_DIV[idx];
  endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Divisor load handshake between the tone sequencer (master) and the frequency divider (slave).
interface tone_sequencer_if;

  logic [31:0] divisor;
  logic        load_req;
  logic        load_ack;

  modport master (
    output divisor,
    output load_req,
    input  load_ack
  );

  modport slave (
    input  divisor,
    input  load_req,
    output load_ack
  );

endinterface

// File: rtl/dwell_timer.sv
// Dwell counter: counts enabled cycles from zero and saturates at limit, flagging expiry there.
module dwell_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] limit,
  output logic        expired
);

  logic [31:0] cnt_q, cnt_d;

  assign expired = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Steps through the note table, loading each divisor over a req/ack handshake and holding it
// for a fixed dwell. Build option TONE_SEQ_LOOP_EN makes the table repeat instead of ending.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned NUM_NOTES    = 8,
  parameter int unsigned DWELL_CYCLES = 25_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         pause,
  tone_sequencer_if.master             load_bus,
  output logic [$clog2(NUM_NOTES)-1:0] note_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned     IdxW       = $clog2(NUM_NOTES);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_NOTES - 1);
  localparam logic [31:0]     DwellLimit = 32'(DWELL_CYCLES - 1);

  seq_state_t      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d, idx_next;
  logic [31:0]     div_q, div_d;
  logic            dwell_en, expired, advance;

  assign idx_next = idx_q + IdxW'(1);
  assign dwell_en = (state_q == DWELL) && !pause;
  // Expiry only counts on an unpaused cycle so a pause delays the advance one-for-one.
  assign advance  = dwell_en && expired;

  dwell_timer u_dwell_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q != DWELL),
    .en      (dwell_en),
    .limit   (DwellLimit),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
          idx_d   = '0;
          div_d   = note_div(3'd0);
        end
      end
      LOAD: begin
        if (load_bus.load_ack) state_d = DWELL;
      end
      DWELL: begin
        if (advance) begin
          if (idx_q != LastIdx) begin
            state_d = LOAD;
            idx_d   = idx_next;
            div_d   = note_div(3'(idx_next));
          end else begin
`ifdef TONE_SEQ_LOOP_EN
            state_d = LOAD;
            idx_d   = '0;
            div_d   = note_div(3'd0);
`else
            state_d = DONE;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
    // Abort keeps the last programmed note visible to the divider.
    if (stop) begin
      state_d = IDLE;
      idx_d   = idx_q;
      div_d   = div_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
    end
  end

  assign load_bus.divisor  = div_q;
  assign load_bus.load_req = (state_q == LOAD);
  assign note_idx          = idx_q;
  assign busy              = (state_q == LOAD) || (state_q == DWELL);
  assign done              = (state_q == DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer with a 3-note table and 4-cycle dwell.
module tb_tone_sequencer;

  localparam int unsigned NumNotes = 3;
  localparam int          Dwell    = 4;
  localparam int          MaxWait  = 40;
  localparam logic [31:0] ExpDiv [3] = '{32'd47801, 32'd42590, 32'd37936};

  typedef struct packed {
    logic [31:0] div;
    logic [1:0]  idx;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] note_idx;
  logic       busy, done;
  int         checks   = 0;
  int         failures = 0;
  int         done_cnt = 0;
  exp_t       sb[$];

  tone_sequencer_if bus ();

  tone_sequencer #(
    .NUM_NOTES    (NumNotes),
    .DWELL_CYCLES (Dwell)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .load_bus (bus),
    .note_idx (note_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    tick();
    bus.load_ack = 1'b1;
    tick();
    bus.load_ack = 1'b0;
  endtask

  // Cycles until load_req or done shows up; -1 if the bound expires.
  task automatic wait_out(output int n);
    n = 0;
    while (bus.load_req !== 1'b1 && done !== 1'b1 && n < MaxWait) begin
      tick();
      n++;
    end
    if (n >= MaxWait) n = -1;
  endtask

  task automatic abort();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.divisor, bus.load_req, note_idx, busy, done} !== 37'd0) begin
      failures++;
      $display("FAIL reset_init: div=%0d req=%b idx=%0d busy=%b done=%b, want all zero",
               bus.divisor, bus.load_req, note_idx, busy, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    pulse_ack();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.divisor, bus.load_req, note_idx, busy, done} !== 37'd0) begin
      failures++;
      $display("FAIL reset_midop: div=%0d req=%b idx=%0d busy=%b done=%b, want all zero",
               bus.divisor, bus.load_req, note_idx, busy, done);
    end
  endtask

  task automatic test_sequence();
    int   n;
    int   want;
    exp_t e;
    for (int i = 0; i < NumNotes; i++) sb.push_back('{div: ExpDiv[i], idx: 2'(i)});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NumNotes; i++) begin
      wait_out(n);
      want = (i == 0) ? 0 : Dwell;
      checks++;
      if (n != want) begin
        failures++;
        $display("FAIL seq_latency note%0d: got %0d cycles, want %0d", i, n, want);
      end
      e = sb.pop_front();
      checks++;
      if (bus.load_req !== 1'b1 || bus.divisor !== e.div || note_idx !== e.idx || busy !== 1'b1)
      begin
        failures++;
        $display("FAIL seq_note%0d: req=%b div=%0d idx=%0d busy=%b, want req=1 div=%0d idx=%0d busy=1",
                 i, bus.load_req, bus.divisor, note_idx, busy, e.div, e.idx);
      end
      pulse_ack();
      checks++;
      if (bus.load_req !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL seq_dwell%0d: req=%b busy=%b, want req=0 busy=1", i, bus.load_req, busy);
      end
    end
    wait_out(n);
    checks++;
    if (n != Dwell) begin
      failures++;
      $display("FAIL seq_end_latency: got %0d cycles, want %0d", n, Dwell);
    end
`ifdef TONE_SEQ_LOOP_EN
    checks++;
    if (bus.load_req !== 1'b1 || done !== 1'b0 || note_idx !== 2'd0 || bus.divisor !== ExpDiv[0])
    begin
      failures++;
      $display("FAIL seq_wrap: req=%b done=%b idx=%0d div=%0d, want req=1 done=0 idx=0 div=%0d",
               bus.load_req, done, note_idx, bus.divisor, ExpDiv[0]);
    end
    abort();
`else
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.load_req !== 1'b0 || note_idx !== 2'd2 ||
        bus.divisor !== ExpDiv[2]) begin
      failures++;
      $display("FAIL seq_done: done=%b busy=%b req=%b idx=%0d div=%0d, want 1 0 0 2 %0d",
               done, busy, bus.load_req, note_idx, bus.divisor, ExpDiv[2]);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || note_idx !== 2'd2) begin
      failures++;
      $display("FAIL seq_after_done: done=%b busy=%b idx=%0d, want done=0 busy=0 idx=2",
               done, busy, note_idx);
    end
`endif
  endtask

  task automatic test_ack_hold();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.load_req !== 1'b1 || bus.divisor !== ExpDiv[0] || note_idx !== 2'd0) begin
        failures++;
        $display("FAIL ack_hold cyc%0d: req=%b div=%0d idx=%0d, want req=1 div=%0d idx=0",
                 i, bus.load_req, bus.divisor, note_idx, ExpDiv[0]);
      end
    end
    pulse_ack();
    wait_out(n);
    checks++;
    if (n != Dwell || bus.divisor !== ExpDiv[1] || note_idx !== 2'd1) begin
      failures++;
      $display("FAIL ack_hold_resume: lat=%0d div=%0d idx=%0d, want lat=%0d div=%0d idx=1",
               n, bus.divisor, note_idx, Dwell, ExpDiv[1]);
    end
    abort();
  endtask

  task automatic test_pause();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulse_ack();
    tick();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pause = 1'b0;
    wait_out(n);
    // One dwell cycle plus the three paused cycles are already behind us.
    checks++;
    if (n != Dwell - 1 || bus.divisor !== ExpDiv[1] || note_idx !== 2'd1) begin
      failures++;
      $display("FAIL pause_delay: lat=%0d div=%0d idx=%0d, want lat=%0d div=%0d idx=1",
               n, bus.divisor, note_idx, Dwell - 1, ExpDiv[1]);
    end
    abort();
  endtask

  task automatic test_stop();
    int n;
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulse_ack();
    wait_out(n);
    pulse_ack();
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.load_req !== 1'b0 || done !== 1'b0 || bus.divisor !== ExpDiv[1] ||
        note_idx !== 2'd1) begin
      failures++;
      $display("FAIL stop_dwell: busy=%b req=%b done=%b div=%0d idx=%0d, want 0 0 0 %0d 1",
               busy, bus.load_req, done, bus.divisor, note_idx, ExpDiv[1]);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.load_req !== 1'b0 || bus.divisor !== ExpDiv[1]) begin
      failures++;
      $display("FAIL start_stop_idle: busy=%b req=%b div=%0d, want busy=0 req=0 div=%0d",
               busy, bus.load_req, bus.divisor, ExpDiv[1]);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL stop_quiet: busy=%b done_pulses=%0d, want busy=0 done_pulses=0",
               busy, done_cnt - d0);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulse_ack();
    tick();
    start        = 1'b1;
    bus.load_ack = 1'b1;
    tick();
    start        = 1'b0;
    bus.load_ack = 1'b0;
    wait_out(n);
    checks++;
    if (n != Dwell - 2 || note_idx !== 2'd1 || bus.divisor !== ExpDiv[1]) begin
      failures++;
      $display("FAIL start_in_dwell: lat=%0d idx=%0d div=%0d, want lat=%0d idx=1 div=%0d",
               n, note_idx, bus.divisor, Dwell - 2, ExpDiv[1]);
    end
    abort();
  endtask

`ifdef TONE_SEQ_LOOP_EN
  task automatic test_loop();
    int   n;
    int   want;
    int   d0;
    exp_t e;
    d0 = done_cnt;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < NumNotes; i++) sb.push_back('{div: ExpDiv[i], idx: 2'(i)});
    sb.push_back('{div: ExpDiv[0], idx: 2'd0});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3 * NumNotes + 1; k++) begin
      wait_out(n);
      want = (k == 0) ? 0 : Dwell;
      e    = sb.pop_front();
      checks++;
      if (n != want || bus.divisor !== e.div || note_idx !== e.idx) begin
        failures++;
        $display("FAIL loop_step%0d: lat=%0d div=%0d idx=%0d, want lat=%0d div=%0d idx=%0d",
                 k, n, bus.divisor, note_idx, want, e.div, e.idx);
      end
      pulse_ack();
    end
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL loop_no_done: done pulses=%0d, want 0", done_cnt - d0);
    end
    abort();
  endtask
`endif

  initial begin
    bus.load_ack = 1'b0;
    test_reset();
    test_sequence();
    test_ack_hold();
    test_pause();
    test_stop();
    test_start_ignored();
`ifdef TONE_SEQ_LOOP_EN
    test_loop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
